// File: rtl/div_controller_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: state encoding, default width, result layout.
package div_defs;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // result_o layout: HI (remainder) in [2*WIDTH-1:WIDTH], LO (quotient) in [WIDTH-1:0]
    function automatic int unsigned hi_lsb(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/div_controller_step.sv
// One combinational radix-2 restoring division iteration.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the WIDTH+1-bit difference cannot wrap and its MSB is the borrow
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div_controller.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage; returns {HI=remainder, LO=quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in one edge when |dividend| < |divisor|.
module div_controller
    import div_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             dvd_sign, quo_sign;
    logic             accept, div_zero, early, last;

    assign mag1     = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2     = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign div_zero = (opdata2_i == '0);
    assign last     = (cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
    assign early = !div_zero && (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    assign quo_fix = quo_sign ? -quo_n : quo_n;
    assign rem_fix = dvd_sign ? -rem_n : rem_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        stall_o = 1'b0;
        accept  = 1'b0;
        if (annul_i) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_i) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    state_d = (div_zero || early) ? DONE : BUSY;
                end
                BUSY: begin
                    stall_o = 1'b1;
                    if (last) state_d = DONE;
                end
                DONE: if (!start_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Reset must clear the stall request even while start_i is held
        if (!resetn) stall_o = 1'b0;
    end

    assign ready_o = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            dvd_sign <= 1'b0;
            quo_sign <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= mag1;
            divisor  <= mag2;
            dvd_sign <= signed_i & opdata1_i[WIDTH-1];
            quo_sign <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            if (div_zero)   result_o <= '0;
            else if (early) result_o <= {opdata1_i, {WIDTH{1'b0}}};
        end else if (state == BUSY && !annul_i) begin
            cnt <= cnt + CW'(1);
            rem <= rem_n;
            quo <= quo_n;
            if (last) result_o <= {rem_fix, quo_fix};
        end
    end

endmodule

// File: doc/div_controller.md
Name: div_controller

Overview:
- Sequences the multi-cycle DIV/DIVU datapath for the MIPS pipeline.
- Accepts operands from EX.
- Runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline stalled while busy, then returns {HI=remainder, LO=quotient} for the HI/LO write.
- Sits beside the ALU in EX. Driven by the decoder's DIV/DIVU classification and by the hazard/flush logic.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start_i  in  1  divide requested by EX; held high until ready_o is seen
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  WIDTH  dividend (rs)
- opdata2_i  in  WIDTH  divisor (rt)
- annul_i  in  1  flush/exception: abort the current operation
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid
- stall_o  out  1  request to stall IF/ID/EX

Behaviour:
- Reset (resetn low, asynchronous, any state including mid-operation):
  - state=IDLE, cnt=0.
  - result_o=0, ready_o=0, stall_o=0.
  - Internal partial remainder/quotient registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with start_i=1 and annul_i=0: latch |opdata1|, |opdata2| (magnitude only if signed_i), dividend sign, and quotient sign (s1 XOR s2).
  - Divisor==0: go straight to DONE with result_o=0. No iterations.
  - Otherwise: cnt=0, go to BUSY.
- BUSY:
  - Each edge performs one restoring step: shift {rem,quo} left 1; trial = rem - divisor; if non-negative, rem=trial and quo[0]=1.
  - cnt increments; the step with cnt==WIDTH-1 is the last and moves to DONE.
  - Sign correction is applied when entering DONE: negate the quotient if the quotient sign is 1; negate the remainder if the dividend sign is 1.
  - Operand inputs and start_i are ignored while BUSY.
- Latency: with the accept edge as E0, DONE is entered on edge E(WIDTH). ready_o is high in the cycle after that edge (33 edges total for WIDTH=32).
- DONE:
  - ready_o=1; result_o stable.
  - Remain in DONE while start_i=1; return to IDLE on the first edge with start_i=0.
  - result_o holds its value until the next accepted operation; ready_o drops in IDLE.
- stall_o is combinational: (IDLE & start_i & ~annul_i) | BUSY. It is 0 in DONE, so the pipeline advances in the ready cycle.
- annul_i:
  - Highest priority after reset.
  - In BUSY or DONE: next state IDLE; result_o unchanged; ready_o=0.
  - stall_o is forced 0 in any cycle where annul_i=1.
- Signed overflow (-2^WIDTH-1 / -1): quotient=0x80000000, remainder=0. No trap.
- Division is by magnitudes at WIDTH bits, with a WIDTH+1-bit trial subtract to capture the borrow.
- Simultaneous start_i and annul_i in IDLE: the request is not accepted.

Optional Feature:
- DIV_EARLY_OUT_EN
- Defined: in IDLE, if the dividend magnitude is less than the nonzero divisor magnitude, go directly to DONE with quotient=0 and remainder=signed dividend (original opdata1_i). Same 1-edge latency as the divide-by-zero path.
- Undefined: such operands take the full WIDTH iterations and produce the same numeric result.

Decomposition:
- Package div_defs holds:
  - state encoding constants (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - default WIDTH;
  - the result layout (HI in [2*WIDTH-1:WIDTH], LO in [WIDTH-1:0]).
- Sub-module div_step: purely combinational single restoring iteration (rem, quo, divisor -> rem', quo'). It is instantiated once and keeps the FSM file readable.

Test Plan:
- DIVU 100/7, start_i held → stall_o=1 for 33 cycles; ready_o in the next cycle; result_o={32'd2, 32'd14}; start_i dropped → IDLE.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 → LO=0xFFFFFFFD, HI=0x00000001.
- DIV 5/0 → DONE after 1 edge, result_o=0, cnt never advances.
- DIVU 0xFFFFFFFF/3, annul_i pulsed at iteration 10 → IDLE next edge, ready_o=0, stall_o=0. Following DIVU 9/3 → {0,3}.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- resetn low mid-BUSY → all outputs 0 immediately. With DIV_EARLY_OUT_EN: DIVU 3/10 → ready after 1 edge, {3,0}.
